// File: rtl/bsram_sd_sync.sv
// Moves cartridge save RAM between SDRAM and the SD save image, one sector at a time,
// through a 512-byte dual-port buffer: load on image mount, write back on save request.
module bsram_sd_sync #(
   parameter int SECTOR_BITS = 9
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic [23:0]            ram_mask,
   input  logic                   img_mounted,
   input  logic [31:0]            img_size,
   input  logic                   save_req,
   output logic [31:0]            sd_lba,
   output logic                   sd_rd,
   output logic                   sd_wr,
   input  logic                   sd_ack,
   input  logic [SECTOR_BITS-1:0] sd_buff_addr,
   input  logic [7:0]             sd_buff_dout,
   input  logic                   sd_buff_wr,
   output logic [7:0]             sd_buff_din,
   output logic [19:0]            mem_addr,
   output logic [7:0]             mem_din,
   input  logic [7:0]             mem_dout,
   output logic                   mem_we,
   output logic                   mem_req,
   input  logic                   mem_ack,
   output logic                   busy
);

   // state   | meaning
   // IDLE    | waiting for a mount (load) or a save request
   // LD_REQ  | sd_rd raised, waiting for sd_ack to rise
   // LD_XFER | user_io streaming a sector into the buffer
   // LD_COPY | copying buffer bytes into BSRAM
   // SV_FILL | reading BSRAM bytes into the buffer
   // SV_REQ  | sd_wr raised, waiting for sd_ack to rise
   // SV_XFER | user_io reading the buffer out to the SD card
   typedef enum logic [2:0] {
      IDLE, LD_REQ, LD_XFER, LD_COPY, SV_FILL, SV_REQ, SV_XFER
   } state_t;

   // per-byte memory sub-phase: buffer read settle, request issue, acknowledge wait
   typedef enum logic [1:0] {M_PRIME, M_ISSUE, M_WAIT} mphase_t;

   localparam int SECTOR_BYTES = 1 << SECTOR_BITS;
   localparam logic [SECTOR_BITS-1:0] IDX_LAST = '1;

   state_t                 state;
   mphase_t                mph;
   logic [SECTOR_BITS-1:0] idx;
   logic [31:0]            img_size_r;
   logic                   mounted;
   logic                   pending;

   logic [7:0]             sec_buf [SECTOR_BYTES];
   logic [7:0]             a_q;
   logic [7:0]             b_q;
   logic                   a_we;
   logic                   b_we;

   logic                   mem_idle;
   logic [19:0]            addr_full;
   logic [32:0]            mask_secs;
   logic [32:0]            sec_n;
   logic [32:0]            img_secs;
   logic [32:0]            sec_l;
   logic [32:0]            lba_next;
   logic                   more_load;
   logic                   more_save;

   assign mem_idle  = (mem_ack == mem_req);
   assign addr_full = 20'({sd_lba, idx}) & ram_mask[19:0];
   assign mask_secs = ({9'd0, ram_mask} + 33'd1) >> SECTOR_BITS;
   assign sec_n     = (mask_secs == 33'd0) ? 33'd1 : mask_secs;
   assign img_secs  = ({1'b0, img_size_r} + 33'(SECTOR_BYTES - 1)) >> SECTOR_BITS;
   assign sec_l     = (img_secs < sec_n) ? img_secs : sec_n;
   assign lba_next  = {1'b0, sd_lba} + 33'd1;
   assign more_load = (lba_next < sec_l);
   assign more_save = (lba_next < sec_n);

   assign a_we = (state == LD_XFER) && sd_buff_wr;
   assign b_we = (state == SV_FILL) && (mph == M_WAIT) && mem_idle;

   // Port A faces user_io, port B faces SDRAM; their writes never overlap in time.
   always_ff @(posedge clk_sys) begin
      if (a_we)
         sec_buf[sd_buff_addr] <= sd_buff_dout;
      else if (b_we)
         sec_buf[idx] <= mem_dout;
      a_q <= sec_buf[sd_buff_addr];
      b_q <= sec_buf[idx];
   end

   assign sd_buff_din = a_q;

   // mem_req is deliberately left out of reset so an in-flight request still completes.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         mph        <= M_PRIME;
         idx        <= '0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         sd_lba     <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         busy       <= 1'b0;
         pending    <= 1'b0;
         mounted    <= 1'b0;
         img_size_r <= '0;
      end else begin
         if (img_mounted) begin
            img_size_r <= img_size;
            if (img_size != 32'd0) mounted <= 1'b1;
         end
         if (save_req) pending <= 1'b1;

         case (state)
            IDLE: begin
               if (img_mounted && img_size != 32'd0 && ram_mask != 24'd0) begin
                  state  <= LD_REQ;
                  sd_lba <= '0;
                  sd_rd  <= 1'b1;
                  busy   <= 1'b1;
               end else if (pending || save_req) begin
                  pending <= 1'b0;
                  if (mounted && ram_mask != 24'd0) begin
                     state  <= SV_FILL;
                     sd_lba <= '0;
                     idx    <= '0;
                     mph    <= M_PRIME;
                     busy   <= 1'b1;
                  end
               end
            end
            LD_REQ: begin
               if (sd_ack) begin
                  sd_rd <= 1'b0;
                  state <= LD_XFER;
               end
            end
            LD_XFER: begin
               if (!sd_ack) begin
                  state <= LD_COPY;
                  idx   <= '0;
                  mph   <= M_PRIME;
               end
            end
            LD_COPY: begin
               case (mph)
                  M_PRIME: mph <= M_ISSUE;
                  M_ISSUE: begin
                     if (mem_idle) begin
                        mem_req  <= ~mem_req;
                        mem_we   <= 1'b1;
                        mem_addr <= addr_full;
                        mem_din  <= b_q;
                        mph      <= M_WAIT;
                     end
                  end
                  default: begin
                     if (mem_idle) begin
                        if (idx == IDX_LAST) begin
                           if (more_load) begin
                              sd_lba <= sd_lba + 32'd1;
                              sd_rd  <= 1'b1;
                              state  <= LD_REQ;
                           end else begin
                              state <= IDLE;
                              busy  <= 1'b0;
                           end
                        end else begin
                           idx <= idx + 1'b1;
                           mph <= M_PRIME;
                        end
                     end
                  end
               endcase
            end
            SV_FILL: begin
               case (mph)
                  M_PRIME: mph <= M_ISSUE;
                  M_ISSUE: begin
                     if (mem_idle) begin
                        mem_req  <= ~mem_req;
                        mem_we   <= 1'b0;
                        mem_addr <= addr_full;
                        mph      <= M_WAIT;
                     end
                  end
                  default: begin
                     if (mem_idle) begin
                        if (idx == IDX_LAST) begin
                           sd_wr <= 1'b1;
                           state <= SV_REQ;
                        end else begin
                           idx <= idx + 1'b1;
                           mph <= M_PRIME;
                        end
                     end
                  end
               endcase
            end
            SV_REQ: begin
               if (sd_ack) begin
                  sd_wr <= 1'b0;
                  state <= SV_XFER;
               end
            end
            SV_XFER: begin
               if (!sd_ack) begin
                  if (more_save) begin
                     sd_lba <= sd_lba + 32'd1;
                     idx    <= '0;
                     mph    <= M_PRIME;
                     state  <= SV_FILL;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bsram_sd_sync.sv
// Bench for bsram_sd_sync: models user_io sector service and a toggle-handshake SDRAM,
// and predicts BSRAM contents and saved image bytes from the load/save rules.
module tb_bsram_sd_sync;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [23:0] ram_mask;
   logic        img_mounted;
   logic [31:0] img_size;
   logic        save_req;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic        sd_buff_wr;
   logic [7:0]  sd_buff_din;
   logic [19:0] mem_addr;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic        mem_we;
   logic        mem_req;
   logic        mem_ack;
   logic        busy;

   bsram_sd_sync #(.SECTOR_BITS(9)) dut (
      .clk_sys(clk_sys), .reset(reset), .ram_mask(ram_mask),
      .img_mounted(img_mounted), .img_size(img_size), .save_req(save_req),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   logic [7:0] mem     [0:8191];
   logic [7:0] exp_mem [0:8191];
   logic [7:0] img     [0:8191];
   logic [7:0] sd_out  [0:8191];
   int rd_lbas[$];
   int wr_lbas[$];
   int toggles = 0, hs_err = 0, mask_err = 0, sd_err = 0;
   bit in_wr = 0;
   int n_cmp = 0, n_bad = 0;

   // SDRAM: acknowledges a toggled request after 0..1 extra cycles, checks hold rules
   initial begin
      logic        pend;
      logic [19:0] a;
      logic [7:0]  d;
      logic        w;
      logic        last_req;
      int          lat;
      mem_ack = 1'b0; mem_dout = 8'd0; pend = 1'b0; lat = 0; a = '0; d = '0; w = 1'b0;
      last_req = mem_req;
      forever begin
         @(negedge clk_sys);
         if (mem_req !== last_req) begin toggles++; last_req = mem_req; end
         if (mem_req !== mem_ack) begin
            if (!pend) begin
               pend = 1'b1; a = mem_addr; d = mem_din; w = mem_we;
               lat = $urandom_range(0, 1);
               if ((mem_addr & ~ram_mask[19:0]) != 20'd0) mask_err++;
            end else if (mem_addr !== a || mem_din !== d || mem_we !== w) hs_err++;
            if (lat == 0) begin
               if (w) mem[a[12:0]] = d;
               else   mem_dout = mem[a[12:0]];
               mem_ack = mem_req;
               pend = 1'b0;
            end else lat--;
         end
      end
   end

   // user_io: serves sd_rd / sd_wr, one buffer byte per clock
   initial begin
      int lba;
      bit w;
      sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (!reset && (sd_rd || sd_wr)) begin
            w = sd_wr; lba = int'(sd_lba);
            if (w) wr_lbas.push_back(lba); else rd_lbas.push_back(lba);
            in_wr = w;
            repeat (1 + $urandom_range(0, 3)) @(negedge clk_sys);
            sd_ack = 1'b1;
            @(negedge clk_sys);
            for (int i = 0; i < 512; i++) begin
               sd_buff_addr = 9'(i);
               if (!w) begin
                  sd_buff_dout = img[(lba * 512 + i) & 8191];
                  sd_buff_wr = 1'b1;
               end
               @(negedge clk_sys);
               if (w) sd_out[(lba * 512 + i) & 8191] = sd_buff_din;
               if (busy && sd_lba !== 32'(lba)) sd_err++;
            end
            sd_buff_wr = 1'b0; sd_ack = 1'b0; in_wr = 0;
         end
      end
   end

   function automatic int sectors(input int mask);
      int n;
      n = (mask + 1) / 512;
      return (n < 1) ? 1 : n;
   endfunction

   // Expected BSRAM after a load: whole sectors up to min(N, ceil(size/512)), masked
   function automatic int model_load(input int mask, input int size);
      int l;
      l = (size + 511) / 512;
      if (l > sectors(mask)) l = sectors(mask);
      for (int s = 0; s < l; s++)
         for (int i = 0; i < 512; i++)
            exp_mem[(s * 512 + i) & mask] = img[s * 512 + i];
      return l;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 8192; i++) begin
         mem[i] = 8'($urandom);
         exp_mem[i] = mem[i];
         img[i] = 8'($urandom);
         sd_out[i] = 8'd0;
      end
   endtask

   task automatic pulse_mount(input logic [31:0] sz);
      img_size = sz; img_mounted = 1'b1;
      @(negedge clk_sys);
      img_mounted = 1'b0;
   endtask

   task automatic pulse_save();
      save_req = 1'b1;
      @(negedge clk_sys);
      save_req = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk_sys);
         if (!busy) begin ok = 1; break; end
      end
   endtask

   task automatic wait_rd_lba(input int lba, output bit ok);
      ok = 0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk_sys);
         if (sd_rd && sd_lba == 32'(lba)) begin ok = 1; break; end
      end
   endtask

   function automatic int mem_diffs();
      int e = 0;
      for (int i = 0; i < 8192; i++) if (mem[i] !== exp_mem[i]) e++;
      return e;
   endfunction

   function automatic int lba_diffs(input int q[$], input int n);
      int e = 0;
      if (q.size() != n) return 1000;
      for (int k = 0; k < n; k++) if (q[k] != k) e++;
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      n_cmp++;
      if ({sd_rd, sd_wr, busy, mem_we, sd_lba, mem_addr, mem_din} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: rd=%0d wr=%0d busy=%0d we=%0d lba=%0d addr=%0h din=%0h, want all 0",
                  sd_rd, sd_wr, busy, mem_we, sd_lba, mem_addr, mem_din);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk_sys);
      n_cmp++;
      if (busy !== 1'b0 || mem_req !== mem_ack) begin
         n_bad++;
         $display("FAIL reset_idle: busy=%0d req=%0d ack=%0d, want busy 0 and req==ack", busy, mem_req, mem_ack);
      end
   endtask

   task automatic test_load_full();
      bit ok;
      int l, e;
      ram_mask = 24'h7FF;
      fill_random();
      rd_lbas.delete();
      l = model_load(32'h7FF, 8192);
      pulse_mount(32'd8192);
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL load_busy_rise: got %0d want 1", busy); end
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL load_timeout: busy still %0d want 0", busy); end
      e = lba_diffs(rd_lbas, l);
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL load_lbas: %0d reads, %0d wrong, want %0d in order", rd_lbas.size(), e, l); end
      e = 0;
      for (int i = 0; i < 512; i++) if (mem[12'h200 + i] !== img[512 + i]) e++;
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL load_sector1: %0d bytes differ from image sector 1, want 0", e); end
      e = mem_diffs();
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL load_bsram: %0d bytes differ, want 0", e); end
   endtask

   task automatic test_save();
      bit ok;
      int e;
      wr_lbas.delete();
      pulse_save();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL save_busy_rise: got %0d want 1", busy); end
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL save_timeout: busy still %0d want 0", busy); end
      e = lba_diffs(wr_lbas, 4);
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL save_lbas: %0d writes, %0d wrong, want 4 in order", wr_lbas.size(), e); end
      n_cmp++;
      if (sd_out[3 * 512 + 511] !== exp_mem[12'h7FF]) begin
         n_bad++; $display("FAIL save_lba3_last: got %0h want %0h", sd_out[3 * 512 + 511], exp_mem[12'h7FF]);
      end
      e = 0;
      for (int i = 0; i < 2048; i++) if (sd_out[i] !== exp_mem[i & 12'h7FF]) e++;
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL save_image: %0d bytes differ, want 0", e); end
      e = mem_diffs();
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL save_bsram_kept: %0d bytes changed, want 0", e); end
   endtask

   task automatic test_no_bsram();
      int nr, nw, tg;
      bit seen = 0;
      ram_mask = 24'h0;
      nr = rd_lbas.size(); nw = wr_lbas.size(); tg = toggles;
      pulse_mount(32'd8192);
      repeat (200) begin @(negedge clk_sys); if (busy) seen = 1; end
      pulse_save();
      repeat (200) begin @(negedge clk_sys); if (busy) seen = 1; end
      n_cmp++;
      if (seen || rd_lbas.size() != nr || wr_lbas.size() != nw || toggles != tg) begin
         n_bad++;
         $display("FAIL no_bsram: busy_seen=%0d new_reads=%0d new_writes=%0d toggles=%0d, want all 0",
                  seen, rd_lbas.size() - nr, wr_lbas.size() - nw, toggles - tg);
      end
   endtask

   task automatic test_partial();
      bit ok;
      int l, e;
      ram_mask = 24'h7FF;
      fill_random();
      rd_lbas.delete();
      l = model_load(32'h7FF, 1000);
      pulse_mount(32'd1000);
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL partial_timeout: busy still %0d want 0", busy); end
      e = lba_diffs(rd_lbas, 2);
      n_cmp++;
      if (e != 0 || l != 2) begin n_bad++; $display("FAIL partial_lbas: %0d reads, %0d wrong, want 2", rd_lbas.size(), e); end
      e = mem_diffs();
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL partial_bsram: %0d bytes differ, want 0", e); end
   endtask

   task automatic test_back_to_back();
      bit ok, ok2, ok3;
      int e, l;
      ram_mask = 24'h7FF;
      fill_random();
      rd_lbas.delete(); wr_lbas.delete();
      l = model_load(32'h7FF, 8192);
      pulse_mount(32'd8192);
      wait_rd_lba(2, ok);
      pulse_save();
      wait_rd_lba(3, ok2);
      pulse_save();
      repeat (3) @(negedge clk_sys);
      pulse_save();
      n_cmp++;
      if (!ok || !ok2) begin n_bad++; $display("FAIL b2b_reach_lba: saw lba2=%0d lba3=%0d, want 1 1", ok, ok2); end
      wait_idle(ok3);
      e = lba_diffs(rd_lbas, l);
      n_cmp++;
      if (!ok3 || e != 0 || wr_lbas.size() != 0) begin
         n_bad++; $display("FAIL b2b_load: done=%0d reads=%0d wrong=%0d writes=%0d, want 1 4 0 0",
                           ok3, rd_lbas.size(), e, wr_lbas.size());
      end
      @(negedge clk_sys);
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_auto_save: busy=%0d want 1", busy); end
      wait_idle(ok);
      repeat (300) @(negedge clk_sys);
      e = lba_diffs(wr_lbas, 4);
      n_cmp++;
      if (!ok || e != 0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL b2b_one_save: writes=%0d wrong=%0d busy=%0d, want 4 0 0", wr_lbas.size(), e, busy);
      end
      e = 0;
      for (int i = 0; i < 2048; i++) if (sd_out[i] !== exp_mem[i]) e++;
      n_cmp++;
      if (e != 0) begin n_bad++; $display("FAIL b2b_image: %0d bytes differ, want 0", e); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen = 0;
      int e, tg, nw;
      ram_mask = 24'h7FF;
      wr_lbas.delete();
      pulse_save();
      ok = 0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk_sys);
         if (in_wr && sd_ack && busy && sd_lba == 32'd1) begin ok = 1; break; end
      end
      repeat (10) @(negedge clk_sys);
      pulse_save();
      reset = 1'b1;
      @(negedge clk_sys);
      n_cmp++;
      if (!ok || sd_ack !== 1'b1 || sd_wr !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid: reached=%0d ack=%0d sd_wr=%0d busy=%0d, want 1 1 0 0", ok, sd_ack, sd_wr, busy);
      end
      reset = 1'b0;
      tg = toggles; nw = wr_lbas.size();
      repeat (700) begin @(negedge clk_sys); if (busy) seen = 1; end
      n_cmp++;
      if (seen || toggles != tg || wr_lbas.size() != nw) begin
         n_bad++; $display("FAIL rst_quiet: busy_seen=%0d toggles=%0d new_writes=%0d, want 0 0 0",
                           seen, toggles - tg, wr_lbas.size() - nw);
      end
      pulse_save();
      repeat (50) begin @(negedge clk_sys); if (busy) seen = 1; end
      n_cmp++;
      if (seen || wr_lbas.size() != nw) begin
         n_bad++; $display("FAIL rst_save_unmounted: busy_seen=%0d new_writes=%0d, want 0 0", seen, wr_lbas.size() - nw);
      end
      // remount with a 256-byte BSRAM: one sector whose halves alias onto the same bytes
      ram_mask = 24'hFF;
      for (int i = 0; i < 8192; i++) begin exp_mem[i] = mem[i]; img[i] = 8'($urandom); sd_out[i] = 8'd0; end
      rd_lbas.delete(); wr_lbas.delete();
      void'(model_load(32'hFF, 8192));
      pulse_mount(32'd8192);
      wait_idle(ok);
      e = mem_diffs();
      n_cmp++;
      if (!ok || lba_diffs(rd_lbas, 1) != 0 || e != 0) begin
         n_bad++; $display("FAIL small_load: done=%0d reads=%0d bytes_wrong=%0d, want 1 1 0", ok, rd_lbas.size(), e);
      end
      pulse_save();
      wait_idle(ok);
      e = 0;
      for (int i = 0; i < 512; i++) if (sd_out[i] !== exp_mem[i & 8'hFF]) e++;
      n_cmp++;
      if (!ok || lba_diffs(wr_lbas, 1) != 0 || e != 0) begin
         n_bad++; $display("FAIL small_save: done=%0d writes=%0d bytes_wrong=%0d, want 1 1 0", ok, wr_lbas.size(), e);
      end
      n_cmp++;
      if (hs_err != 0 || mask_err != 0 || sd_err != 0) begin
         n_bad++; $display("FAIL protocol: hold_errs=%0d mask_errs=%0d lba_errs=%0d, want 0 0 0", hs_err, mask_err, sd_err);
      end
   endtask

   initial begin
      reset = 1'b1; ram_mask = 24'h7FF; img_mounted = 1'b0; img_size = '0; save_req = 1'b0;
      test_reset();
      test_load_full();
      test_save();
      test_no_bsram();
      test_partial();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
